bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter (iterative shift-add-3, "double dabble"). It sits directly downstream of the shift-register/LFSR stage and upstream of the per-digit seven-segment decoders. It takes the WIDTH-bit binary value and produces DIGITS packed BCD nibbles, so the display shows the value in decimal instead of raw hex. It uses a valid/ready handshake on both sides so it can sit between a free-running producer and a slower consumer.

Parameters:
WIDTH, 8, width of binary input.
DIGITS, 3, number of BCD output digits. Elaboration error if 10^DIGITS - 1 < 2^WIDTH - 1.

Ports:
clk_i  input  1  rising-edge clock.
rst_i  input  1  synchronous reset, active-high.
in_valid_i  input  1  data_i holds a value to convert.
in_ready_o  output  1  converter can accept; high only in IDLE.
data_i  input  WIDTH  unsigned binary value.
out_valid_o  output  1  bcd_o holds a completed result.
out_ready_i  input  1  consumer takes the result.
bcd_o  output  4*DIGITS  packed BCD; digit 0 (ones) in bcd_o[3:0], digit k in bcd_o[4k+3:4k].

Behaviour:
- Reset (rst_i high at a clock edge): state=IDLE, bcd_o=0, out_valid_o=0, in_ready_o=1, shift counter=0. Reset aborts any conversion in flight; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready_o=1. On in_valid_i & in_ready_o at edge T: load bin shift reg = data_i, scratch BCD reg = 0, counter = 0; go to SHIFT.
- SHIFT: one iteration per cycle. Each iteration:
  - Every scratch digit >= 5 gets +3 (4-bit, no carry out of the nibble).
  - Then {scratch, bin} is shifted left by 1.
  - counter increments.
- SHIFT exit: the edge that performs iteration WIDTH (counter = WIDTH-1 before that edge) copies the post-shift scratch to bcd_o and moves to DONE.
- Latency: out_valid_o is high in the cycle after edge T+WIDTH, i.e. WIDTH cycles after the acceptance edge.
- DONE: out_valid_o=1, bcd_o stable. On out_ready_i high at an edge: go to IDLE, out_valid_o=0.
- bcd_o keeps its last result after the handshake; it changes only on DONE entry or reset.
- in_valid_i is ignored outside IDLE; in_ready_o=0 in SHIFT and DONE. There is no bypass: if out_ready_i and in_valid_i are both high in DONE, the new input is accepted no earlier than the next cycle (in IDLE).
- out_ready_i is ignored outside DONE.
- data_i is sampled only at the acceptance edge; later changes do not affect the conversion in progress.
- Counter width: $clog2(WIDTH+1). Scratch width: 4*DIGITS. Overflow cannot occur given the elaboration check.
- Throughput, with out_ready_i held high: one result per WIDTH+2 cycles.

Decomposition:
- Package bin2bcd_pkg:
  - state enum (IDLE, SHIFT, DONE), 2-bit.
  - localparam BCD_W = 4.
  - localparam ADJ_THRESH = 4'd5.
  - localparam ADJ_ADD = 4'd3.
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, output = in >= 5 ? in + 3 : in. Instantiated DIGITS times with a generate loop.
- FSM, counter and shift registers stay in bin2bcd_seq.

Test Plan:
- Reset then data_i=8'd0 with in_valid_i=1 -> out_valid_o rises 8 cycles after acceptance, bcd_o=12'h000; in_ready_o low throughout SHIFT/DONE.
- data_i=8'd255, out_ready_i=1 -> bcd_o=12'h255, one cycle in DONE, then IDLE with in_ready_o=1.
- data_i sweep 8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199 -> bcd_o 12'h001, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199. Exhaustive 0..255 compared against a reference model.
- Back-pressure: convert 8'd42 with out_ready_i=0 for 5 cycles -> out_valid_o and bcd_o=12'h042 held stable, in_valid_i ignored. Release -> IDLE next cycle, bcd_o still 12'h042.
- Reset mid-conversion: accept 8'd200, assert rst_i at the 4th SHIFT cycle -> next cycle IDLE, bcd_o=0, out_valid_o=0. A following conversion of 8'd7 yields 12'h007.
- Chained with an 8-bit LFSR seeded 8'h01 feeding data_i -> each bcd_o equals the decimal of the LFSR value; data_i changes during SHIFT do not corrupt the result.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
   localparam logic [BCD_W-1:0] ADJ_ADD = 4'd3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction applied to one BCD digit before each double-dabble shift
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [BCD_W-1:0] d_i,
   output logic [BCD_W-1:0] d_o
);
   assign d_o = (d_i >= ADJ_THRESH) ? d_i + ADJ_ADD : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary-to-BCD converter with valid/ready on both sides
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [WIDTH-1:0]          data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [BCD_W*DIGITS-1:0]   bcd_o
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = BCD_W * DIGITS;

   if (10.0 ** DIGITS - 1.0 < 2.0 ** WIDTH - 1.0) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for WIDTH");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [SW-1:0]   scr_q, scr_d, scr_adj, bcd_q, bcd_d;
   logic [SW+WIDTH-1:0] sh;
   logic            accept, last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .d_i(scr_q[g*BCD_W +: BCD_W]),
         .d_o(scr_adj[g*BCD_W +: BCD_W])
      );
   end

   assign sh     = {scr_adj, bin_q} << 1;
   assign accept = (state_q == IDLE) && in_valid_i;
   assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         scr_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         scr_q   <= scr_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_valid_i ? SHIFT : IDLE;
         SHIFT:   state_d = last ? DONE : SHIFT;
         DONE:    state_d = out_ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d = accept ? '0 : (state_q == SHIFT) ? cnt_q + 1'b1 : cnt_q;
      bin_d = accept ? data_i : (state_q == SHIFT) ? sh[WIDTH-1:0] : bin_q;
      scr_d = accept ? '0 : (state_q == SHIFT) ? sh[SW+WIDTH-1:WIDTH] : scr_q;
      bcd_d = last ? sh[SW+WIDTH-1:WIDTH] : bcd_q;
   end

   always_comb begin
      in_ready_o  = (state_q == IDLE);
      out_valid_o = (state_q == DONE);
      bcd_o       = bcd_q;
   end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and exhaustive checks of bin2bcd_seq against decimal expectations
module tb_bin2bcd_seq;
   logic        clk = 0;
   logic        rst_i = 1;
   logic        in_valid_i = 0;
   logic        in_ready_o;
   logic [7:0]  data_i = 0;
   logic        out_valid_o;
   logic        out_ready_i = 0;
   logic [11:0] bcd_o;
   int          total = 0;
   int          bad = 0;

   bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
      .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .data_i(data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .bcd_o(bcd_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] dec(input logic [7:0] v);
      int x;
      x = int'(v);
      return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic convert(input logic [7:0] v, input logic [11:0] exp, input string tag);
      int n;
      logic seen;
      n = 0;
      while (!in_ready_o && n < 20) begin tick(); n++; end
      chk({tag, "_rdy"}, in_ready_o, 1);
      data_i = v;
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      data_i = 8'($urandom);
      n = 0;
      seen = 0;
      while (!out_valid_o && n < 20) begin
         seen |= in_ready_o;
         tick();
         data_i = 8'($urandom);
         n++;
      end
      seen |= in_ready_o;
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_busy"}, seen, 0);
      chk({tag, "_bcd"}, bcd_o, exp);
      out_ready_i = 1;
      tick();
      out_ready_i = 0;
      chk({tag, "_idle"}, {in_ready_o, out_valid_o}, 2'b10);
      chk({tag, "_keep"}, bcd_o, exp);
   endtask

   logic [7:0] lfsr;
   logic [7:0] dv[6] = '{8'd1, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199};
   logic [11:0] de[6] = '{12'h001, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199};

   initial begin
      repeat (2) tick();
      rst_i = 0;
      chk("rst", {in_ready_o, out_valid_o}, 2'b10);
      chk("rst_bcd", bcd_o, 0);
      convert(8'd0, 12'h000, "zero");
      out_ready_i = 1;
      data_i = 8'd255;
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      repeat (8) tick();
      chk("max_done", {out_valid_o, in_ready_o}, 2'b10);
      chk("max_bcd", bcd_o, 12'h255);
      tick();
      chk("max_idle", {out_valid_o, in_ready_o}, 2'b01);
      out_ready_i = 0;
      for (int i = 0; i < 6; i++) convert(dv[i], de[i], "sweep");
      data_i = 8'd42;
      in_valid_i = 1;
      tick();
      data_i = 8'd99;
      repeat (8) tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", {out_valid_o, in_ready_o}, 2'b10);
         chk("bp_bcd", bcd_o, 12'h042);
         tick();
      end
      out_ready_i = 1;
      tick();
      in_valid_i = 0;
      out_ready_i = 0;
      chk("bp_rel", {out_valid_o, in_ready_o}, 2'b01);
      chk("bp_keep", bcd_o, 12'h042);
      data_i = 8'd200;
      in_valid_i = 1;
      tick();
      in_valid_i = 0;
      repeat (3) tick();
      rst_i = 1;
      tick();
      rst_i = 0;
      chk("abort", {out_valid_o, in_ready_o}, 2'b01);
      chk("abort_bcd", bcd_o, 0);
      tick();
      chk("abort_stay", {out_valid_o, in_ready_o}, 2'b01);
      convert(8'd7, 12'h007, "after_abort");
      for (int v = 0; v < 256; v++) convert(8'(v), dec(8'(v)), "exh");
      lfsr = 8'h01;
      for (int i = 0; i < 20; i++) begin
         convert(lfsr, dec(lfsr), "lfsr");
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
